// File: rtl/alu_pipe.sv
// Handshaked pipeline ALU with a single-entry registered output and an iterative shift-add multiplier.
// Optional feature: define ALU_PIPE_ABSDIFF_EN to enable op 14 (unsigned |a-b|); otherwise op 14 is illegal.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [4:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_MUL     = 5'd2,
    OP_AND     = 5'd3,
    OP_OR      = 5'd4,
    OP_NOR     = 5'd5,
    OP_XOR     = 5'd6,
    OP_SLL     = 5'd7,
    OP_SRL     = 5'd8,
    OP_SRA     = 5'd9,
    OP_SLT     = 5'd10,
    OP_SLTU    = 5'd11,
    OP_EQ      = 5'd12,
    OP_NE      = 5'd13,
    OP_ABSDIFF = 5'd14
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   count_q, count_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_sum;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             consume;

  assign shamt    = b[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // Single-cycle datapath; illegal ops leave alu_res at zero.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, (a != b)};
`ifdef ALU_PIPE_ABSDIFF_EN
      OP_ABSDIFF: alu_res = (a >= b) ? (a - b) : (b - a);
`else
      OP_ABSDIFF: alu_ill = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    busy_d      = busy_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;

    if (consume) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // Final step folds this cycle's addend straight into the result.
        if (count_q == SHW'(WIDTH-1)) begin
          result_d    = acc_sum;
          zero_d      = (acc_sum == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe (WIDTH=32) against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns {illegal, result} from the opcode rules.
  function automatic logic [W:0] model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0]  prod;
    logic [W-1:0] r;
    int unsigned  sh;
    sh = int'(y[4:0]);
    r  = '0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  begin prod = {32'd0, x} * {32'd0, y}; r = prod[W-1:0]; end
      5'd3:  r = x & y;
      5'd4:  r = x | y;
      5'd5:  r = ~(x | y);
      5'd6:  r = x ^ y;
      5'd7:  r = x << sh;
      5'd8:  r = x >> sh;
      5'd9:  r = (x >> sh) | (x[W-1] ? ~({W{1'b1}} >> sh) : '0);
      5'd10: r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 1 : 0;
      5'd11: r = (x < y) ? 1 : 0;
      5'd12: r = (x == y) ? 1 : 0;
      5'd13: r = (x != y) ? 1 : 0;
`ifdef ALU_PIPE_ABSDIFF_EN
      5'd14: r = (x >= y) ? x - y : y - x;
`else
      5'd14: return {1'b1, {W{1'b0}}};
`endif
      default: return {1'b1, {W{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  // Issue one op with out_ready=1, wait for its result and compare against the model.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int stall);
    logic [W:0]   exp;
    logic [W-1:0] held;
    int n;
    exp = model(o, x, y);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    in_valid = 1'b0; op = $urandom; a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid && n < W + 4) begin tick(); n++; end
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk({tag, "_result"}, result, exp[W-1:0]);
    chk({tag, "_zero"}, W'(zero), W'(exp[W-1:0] == '0));
    chk({tag, "_illegal"}, W'(illegal), W'(exp[W]));
    if (stall > 0) begin
      held = result;
      out_ready = 1'b0;
      repeat (stall) begin
        tick();
        chk({tag, "_hold"}, result, held);
        chk({tag, "_holdv"}, W'(out_valid), W'(1));
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic saw;
    logic [4:0] ro;
    // Reset with random inputs toggling.
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      in_valid = 1'(($urandom)); op = 5'($urandom); a = $urandom; b = $urandom;
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_illegal", W'(illegal), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_valid2", W'(out_valid), W'(0));

    // Back-to-back single-cycle ops.
    in_valid = 1'b1; op = 5'd0; a = 5; b = 7;
    tick();
    chk("b2b_add", result, 32'd12);
    chk("b2b_add_z", W'(zero), W'(0));
    chk("b2b_add_v", W'(out_valid), W'(1));
    op = 5'd1; a = 7; b = 7;
    tick();
    chk("b2b_sub", result, 32'd0);
    chk("b2b_sub_z", W'(zero), W'(1));
    op = 5'd10; a = 32'hFFFF_FFFF; b = 1;
    tick();
    chk("b2b_slt", result, 32'd1);
    chk("b2b_slt_v", W'(out_valid), W'(1));
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", W'(out_valid), W'(0));

    // Multiply latency and busy window.
    in_valid = 1'b1; op = 5'd2; a = 32'h0001_0003; b = 32'h0000_0005;
    tick();
    in_valid = 1'b0;
    chk("mul_busy0", W'(busy), W'(1));
    chk("mul_rdy0", W'(in_ready), W'(0));
    for (int i = 1; i < W; i++) begin
      tick();
      chk("mul_busy", W'(busy), W'(1));
      chk("mul_rdy", W'(in_ready), W'(0));
      chk("mul_nv", W'(out_valid), W'(0));
    end
    tick();
    chk("mul_v", W'(out_valid), W'(1));
    chk("mul_res", result, 32'h0005_000F);
    chk("mul_busy_end", W'(busy), W'(0));
    tick();
    run_op("mul_wrap", 5'd2, 32'hFFFF_FFFF, 32'd2, 0);
    chk("mul_wrap_c", result, 32'hFFFF_FFFE);

    // Backpressure with a pending op.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 5'd6; a = 32'h0000_F0F0; b = 32'h0000_0FF0;
    tick();
    chk("bp_xor", result, 32'h0000_FF00);
    op = 5'd0; a = 1; b = 1;
    repeat (5) begin
      tick();
      chk("bp_hold", result, 32'h0000_FF00);
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_rdy", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", W'(in_ready), W'(1));
    tick();
    chk("bp_new", result, 32'd2);
    chk("bp_new_v", W'(out_valid), W'(1));
    in_valid = 1'b0;
    tick();

    // Illegal op and the optional op 14.
    run_op("ill31", 5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    chk("ill31_flag", W'(illegal), W'(1));
    run_op("op14", 5'd14, 32'd3, 32'd10, 0);
`ifdef ALU_PIPE_ABSDIFF_EN
    chk("op14_val", result, 32'd7);
`else
    chk("op14_ill", W'(illegal), W'(1));
`endif
    tick();

    // Reset during multiply discards it.
    in_valid = 1'b1; op = 5'd2; a = 32'h0000_1234; b = 32'h0000_0077;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", W'(busy), W'(0));
    chk("mrst_valid", W'(out_valid), W'(0));
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (W + 8) begin
      tick();
      saw = saw | out_valid | busy;
    end
    chk("mrst_noresult", W'(saw), W'(0));
    run_op("sra", 5'd9, 32'h8000_0000, 32'd4, 0);
    chk("sra_val", result, 32'hF800_0000);

    // Randomized ops with occasional backpressure.
    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      run_op("rand", ro, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
